// File: rtl/seq_alu.sv
// Registered multi-cycle ALU: single-cycle add/sub/logic/shift ops plus an
// iterative shift-add multiply, persistent flags and a start/ready/done handshake.
//
// state  | meaning
// IDLE   | ready; single-cycle ops complete at the accepting edge
// MUL    | shift-add iterations in progress; start ignored
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_ADC = 4'd2;
  localparam logic [3:0] OP_SBC = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 c_q, c_d, z_q, z_d, n_q, n_d, v_q, v_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     alu_res;
  logic                 alu_c, alu_v, alu_legal;
  logic [WIDTH-1:0]     b_eff;
  logic                 cin;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   step, prod;

  // b' and carry-in selection; SUB/SBC use the a + ~b + cin form
  always_comb begin
    alu_res   = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    alu_legal = 1'b1;
    b_eff     = ((op == OP_SUB) || (op == OP_SBC)) ? ~b : b;
    case (op)
      OP_SUB:          cin = 1'b1;
      OP_ADC, OP_SBC:  cin = c_q;
      default:         cin = 1'b0;
    endcase
    sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    case (op)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SHL: begin
        alu_res = {a[WIDTH-2:0], 1'b0};
        alu_c   = a[WIDTH-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, a[WIDTH-1:1]};
        alu_c   = a[0];
      end
      default: alu_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    result_d = result_q;
    c_d      = c_q;
    z_d      = z_q;
    n_d      = n_q;
    v_d      = v_q;
    done_d   = 1'b0;
    step     = acc_q + (mplier_q[0] ? mcand_q : '0);
    prod     = step + (mplier_q[1] ? {mcand_q[2*WIDTH-2:0], 1'b0} : '0);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = CNT_W'(WIDTH);
            state_d  = S_MUL;
          end else begin
            done_d = 1'b1;
            if (alu_legal) begin
              result_d = alu_res;
              c_d      = alu_c;
              z_d      = (alu_res == '0);
              n_d      = alu_res[WIDTH-1];
              v_d      = alu_v;
            end
          end
        end
      end
      S_MUL: begin
        // The last cycle retires the two remaining multiplier bits so the
        // result lands WIDTH cycles after start.
        if (cnt_q == CNT_W'(2)) begin
          result_d = prod[WIDTH-1:0];
          c_d      = |prod[2*WIDTH-1:WIDTH];
          z_d      = (prod[WIDTH-1:0] == '0);
          n_d      = prod[WIDTH-1];
          v_d      = 1'b0;
          done_d   = 1'b1;
          cnt_d    = '0;
          state_d  = S_IDLE;
        end else begin
          acc_d    = step;
          mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
          mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
          cnt_d    = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      c_q      <= c_d;
      z_q      <= z_d;
      n_q      <= n_d;
      v_q      <= v_d;
      done_q   <= done_d;
    end
  end

  assign ready  = (state_q == S_IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign flag_c = c_q;
  assign flag_z = z_q;
  assign flag_n = n_q;
  assign flag_v = v_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: vector table through a scoreboard, plus
// hand-written multiply, reset-abort and 16-bit sequences.
module tb_seq_alu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, start, ready, done, fc, fz, fn, fv;
  logic [3:0] op;
  logic [7:0] a, b, result;

  logic        start16, ready16, done16, fc16, fz16, fn16, fv16;
  logic [3:0]  op16;
  logic [15:0] a16, b16, result16;

  seq_alu #(.WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .ready(ready), .done(done), .result(result),
    .flag_c(fc), .flag_z(fz), .flag_n(fn), .flag_v(fv)
  );

  seq_alu #(.WIDTH(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .start(start16), .op(op16), .a(a16), .b(b16),
    .ready(ready16), .done(done16), .result(result16),
    .flag_c(fc16), .flag_z(fz16), .flag_n(fn16), .flag_v(fv16)
  );

  int errors = 0;
  int checks = 0;
  int dones8 = 0;

  // flags packed as {c, z, n, v}
  typedef struct {
    logic [7:0] res;
    logic [3:0] f;
  } exp_t;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] f;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n && done) begin
      dones8++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: actual=done required=no done");
      end else begin
        e = sb.pop_front();
        chk("sb_result", {24'd0, result}, {24'd0, e.res});
        chk("sb_flags", {28'd0, fc, fz, fn, fv}, {28'd0, e.f});
      end
    end
  end

  task automatic drain(input int max);
    int n = 0;
    while (sb.size() != 0 && n < max) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: actual=%0d pending required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic push(input logic [7:0] r, input logic [3:0] f);
    exp_t e;
    e.res = r;
    e.f   = f;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int lat;
    reset_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    start16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;

    vecs = '{
      '{4'd0, 8'hFF, 8'h01, 8'h00, 4'b1100},
      '{4'd2, 8'h00, 8'h00, 8'h01, 4'b0000},
      '{4'd1, 8'h05, 8'h07, 8'hFE, 4'b0010},
      '{4'd1, 8'h80, 8'h01, 8'h7F, 4'b1001},
      '{4'd4, 8'hF0, 8'h0F, 8'h00, 4'b0100},
      '{4'd3, 8'h10, 8'h01, 8'h0E, 4'b1000},
      '{4'd5, 8'h50, 8'h0A, 8'h5A, 4'b0000},
      '{4'd6, 8'hFF, 8'h0F, 8'hF0, 4'b0010},
      '{4'd7, 8'h81, 8'h00, 8'h02, 4'b1000},
      '{4'd8, 8'h81, 8'h00, 8'h40, 4'b1000},
      '{4'd0, 8'h01, 8'h02, 8'h03, 4'b0000},
      '{4'hC, 8'h55, 8'h66, 8'h03, 4'b0000},
      '{4'd0, 8'h7F, 8'h01, 8'h80, 4'b0011},
      '{4'hF, 8'h12, 8'h34, 8'h80, 4'b0011},
      '{4'd2, 8'hFF, 8'h00, 8'hFF, 4'b0010},
      '{4'd1, 8'h01, 8'h01, 8'h00, 4'b1100},
      '{4'd2, 8'h03, 8'h04, 8'h08, 4'b0000}
    };

    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", {24'd0, result}, 32'd0);
    chk("rst_flags", {28'd0, fc, fz, fn, fv}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ready16", {31'd0, ready16}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // back-to-back single-cycle ops
    for (int i = 0; i < 17; i++) begin
      start = 1'b1; op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
      push(vecs[i].res, vecs[i].f);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    drain(5);
    @(posedge clk);
    #1;

    // MUL 0x10*0x20 with an ignored start in cycle 3
    d0 = dones8;
    start = 1'b1; op = 4'd9; a = 8'h10; b = 8'h20;
    push(8'h00, 4'b1100);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      start = (c == 3); op = 4'd0; a = 8'h01; b = 8'h01;
      @(negedge clk);
      chk($sformatf("mul_ready_c%0d", c), {31'd0, ready}, (c == 8) ? 32'd1 : 32'd0);
      chk($sformatf("mul_done_c%0d", c), {31'd0, done}, (c == 8) ? 32'd1 : 32'd0);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("mul_one_done", dones8 - d0, 32'd1);

    start = 1'b1; op = 4'd9; a = 8'h0F; b = 8'h0F;
    push(8'hE1, 4'b0010);
    @(posedge clk);
    #1;
    start = 1'b0;
    drain(20);
    @(posedge clk);
    #1;

    // reset in cycle 4 of a MUL aborts it
    start = 1'b1; op = 4'd9; a = 8'h03; b = 8'h05;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_busy", {31'd0, ready}, 32'd0);
    d0 = dones8;
    reset_n = 1'b0;
    #1;
    chk("abort_result", {24'd0, result}, 32'd0);
    chk("abort_flags", {28'd0, fc, fz, fn, fv}, 32'd0);
    chk("abort_ready", {31'd0, ready}, 32'd1);
    chk("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("abort_no_done", dones8 - d0, 32'd0);

    // 16-bit instance
    start16 = 1'b1; op16 = 4'd0; a16 = 16'hFFFF; b16 = 16'h0001;
    @(posedge clk);
    #1;
    start16 = 1'b0;
    @(negedge clk);
    chk("w16_add_done", {31'd0, done16}, 32'd1);
    chk("w16_add_result", {16'd0, result16}, 32'd0);
    chk("w16_add_flags", {28'd0, fc16, fz16, fn16, fv16}, 32'b1100);
    @(posedge clk);
    #1;
    start16 = 1'b1; op16 = 4'd9; a16 = 16'h00FF; b16 = 16'h0101;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      start16 = 1'b0;
      @(negedge clk);
      if (done16) begin
        lat = n;
        break;
      end
    end
    chk("w16_mul_latency", lat, 32'd16);
    chk("w16_mul_result", {16'd0, result16}, 32'hFFFF);
    chk("w16_mul_flags", {28'd0, fc16, fz16, fn16, fv16}, 32'b0010);

    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
